// File: rtl/bp_stream_state_pkg.sv
// Shared constants and width helper for the BedRock stream pump beat-state slice.
package bp_stream_state_pkg;

   localparam int default_stream_words = 8;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int safe_width(input int max_val);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) <= max_val) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/bp_stream_beat_counter.sv
// Settable, enabled beat counter with an explicit wrap at max_val_p.
module bp_stream_beat_counter
   import bp_stream_state_pkg::*;
#(
   parameter int max_val_p   = default_stream_words - 1,
   parameter int reset_val_p = 0,
   localparam int cw_lp      = safe_width(max_val_p)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             set_i,
   input  logic             en_i,
   input  logic [cw_lp-1:0] val_i,
   output logic [cw_lp-1:0] cnt_o
);

   localparam logic [cw_lp-1:0] max_lp   = cw_lp'(max_val_p);
   localparam logic [cw_lp-1:0] reset_lp = cw_lp'(reset_val_p);

   logic [cw_lp-1:0] cnt_q;
   logic [cw_lp-1:0] cnt_d;

   // Compare with >= so an out-of-range load still wraps on the next increment.
   always_comb begin
      cnt_d = cnt_q;
      if (set_i) begin
         cnt_d = val_i;
      end else if (en_i) begin
         cnt_d = (cnt_q >= max_lp) ? '0 : cnt_q + cw_lp'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= reset_lp;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/bp_stream_beat_state.sv
// Per-transaction beat counter, streaming flag and critical-address bypass register.
// Define BP_STREAM_BEAT_STATE_ASSERT_EN to compile in simulation-only legality checks.
module bp_stream_beat_state
   import bp_stream_state_pkg::*;
#(
   parameter int max_val_p        = default_stream_words - 1,
   parameter int reset_val_p      = 0,
   parameter int clear_over_set_p = 1,
   parameter int byp_width_p      = 6,
   localparam int cw_lp           = safe_width(max_val_p)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   cnt_set_i,
   input  logic                   cnt_en_i,
   input  logic [cw_lp-1:0]       cnt_val_i,
   output logic [cw_lp-1:0]       cnt_o,
   input  logic                   flag_set_i,
   input  logic                   flag_clear_i,
   output logic                   flag_o,
   input  logic                   byp_en_i,
   input  logic [byp_width_p-1:0] byp_data_i,
   output logic [byp_width_p-1:0] byp_data_o
);

   bp_stream_beat_counter #(
      .max_val_p   (max_val_p),
      .reset_val_p (reset_val_p)
   ) u_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .set_i   (cnt_set_i),
      .en_i    (cnt_en_i),
      .val_i   (cnt_val_i),
      .cnt_o   (cnt_o)
   );

   logic flag_q;
   logic flag_d;

   // Simultaneous set and clear resolves to whichever side clear_over_set_p favours.
   always_comb begin
      flag_d = flag_q;
      if (flag_set_i && flag_clear_i) begin
         flag_d = (clear_over_set_p == 0);
      end else if (flag_set_i) begin
         flag_d = 1'b1;
      end else if (flag_clear_i) begin
         flag_d = 1'b0;
      end
   end

   logic [byp_width_p-1:0] byp_q;
   logic [byp_width_p-1:0] byp_d;

   always_comb begin
      byp_d = byp_q;
      if (byp_en_i) begin
         byp_d = byp_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         flag_q <= 1'b0;
         byp_q  <= '0;
      end else begin
         flag_q <= flag_d;
         byp_q  <= byp_d;
      end
   end

   assign flag_o     = flag_q;
   assign byp_data_o = byp_en_i ? byp_data_i : byp_q;

`ifdef BP_STREAM_BEAT_STATE_ASSERT_EN
   if (reset_val_p > max_val_p) begin : g_bad_reset_val
      $error("bp_stream_beat_state: reset_val_p (%0d) exceeds max_val_p (%0d)",
             reset_val_p, max_val_p);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (cnt_set_i && (int'(cnt_val_i) > max_val_p)) begin
            $error("bp_stream_beat_state: load value %0d exceeds max_val_p %0d",
                   cnt_val_i, max_val_p);
         end
         if (flag_set_i && flag_clear_i &&
             (clear_over_set_p != 0) && (clear_over_set_p != 1)) begin
            $error("bp_stream_beat_state: clear_over_set_p %0d is not 0 or 1",
                   clear_over_set_p);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_bp_stream_beat_state.sv
// Randomized self-checking bench: two configurations checked against a behavioural model.
module tb_bp_stream_beat_state;

   logic       clk;
   logic       rst;
   logic       cnt_set;
   logic       cnt_en;
   logic [2:0] cnt_val;
   logic       flag_set;
   logic       flag_clear;
   logic       byp_en;
   logic [5:0] byp_data;

   logic [2:0] cnt_a;
   logic       flag_a;
   logic [5:0] byp_a;
   logic [2:0] cnt_b;
   logic       flag_b;
   logic [3:0] byp_b;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // Model state: configuration A is the default build, B is max 5 / reset 2 / set-wins.
   int         m_cnt_a   = 0;
   int         m_cnt_b   = 2;
   bit         m_flag_a  = 1'b0;
   bit         m_flag_b  = 1'b0;
   logic [5:0] m_store_a = '0;
   logic [3:0] m_store_b = '0;

   bp_stream_beat_state dut_a (
      .clk_i        (clk),
      .reset_i      (rst),
      .cnt_set_i    (cnt_set),
      .cnt_en_i     (cnt_en),
      .cnt_val_i    (cnt_val),
      .cnt_o        (cnt_a),
      .flag_set_i   (flag_set),
      .flag_clear_i (flag_clear),
      .flag_o       (flag_a),
      .byp_en_i     (byp_en),
      .byp_data_i   (byp_data),
      .byp_data_o   (byp_a)
   );

   bp_stream_beat_state #(
      .max_val_p        (5),
      .reset_val_p      (2),
      .clear_over_set_p (0),
      .byp_width_p      (4)
   ) dut_b (
      .clk_i        (clk),
      .reset_i      (rst),
      .cnt_set_i    (cnt_set),
      .cnt_en_i     (cnt_en),
      .cnt_val_i    (cnt_val),
      .cnt_o        (cnt_b),
      .flag_set_i   (flag_set),
      .flag_clear_i (flag_clear),
      .flag_o       (flag_b),
      .byp_en_i     (byp_en),
      .byp_data_i   (byp_data[3:0]),
      .byp_data_o   (byp_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int next_count(input int cur, input int maxv);
      if (cnt_set) return int'(cnt_val);
      if (cnt_en) return (cur >= maxv) ? 0 : cur + 1;
      return cur;
   endfunction

   function automatic bit next_flag(input bit cur, input bit clear_wins);
      if (flag_set && flag_clear) return !clear_wins;
      if (flag_set) return 1'b1;
      if (flag_clear) return 1'b0;
      return cur;
   endfunction

   // Behavioural model advances on the same edges the design sees.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt_a   = 0;
         m_cnt_b   = 2;
         m_flag_a  = 1'b0;
         m_flag_b  = 1'b0;
         m_store_a = '0;
         m_store_b = '0;
      end else begin
         m_cnt_a  = next_count(m_cnt_a, 7);
         m_cnt_b  = next_count(m_cnt_b, 5);
         m_flag_a = next_flag(m_flag_a, 1'b1);
         m_flag_b = next_flag(m_flag_b, 1'b0);
         if (byp_en) begin
            m_store_a = byp_data;
            m_store_b = byp_data[3:0];
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check_output("model cnt_a", 32'(cnt_a), 32'(m_cnt_a));
         check_output("model cnt_b", 32'(cnt_b), 32'(m_cnt_b));
         check_output("model flag_a", 32'(flag_a), 32'(m_flag_a));
         check_output("model flag_b", 32'(flag_b), 32'(m_flag_b));
         check_output("model byp_a", 32'(byp_a), 32'(byp_en ? byp_data : m_store_a));
         check_output("model byp_b", 32'(byp_b), 32'(byp_en ? byp_data[3:0] : m_store_b));
      end
   end

   task automatic apply_stimulus(input bit set, input bit en, input logic [2:0] val,
                                 input bit fs, input bit fc, input bit be, input logic [5:0] bd);
      #1;
      cnt_set    = set;
      cnt_en     = en;
      cnt_val    = val;
      flag_set   = fs;
      flag_clear = fc;
      byp_en     = be;
      byp_data   = bd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   int exp_wrap_a[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
   int exp_wrap_b[9] = '{3, 4, 5, 0, 1, 2, 3, 4, 5};
   int exp_np2_b[7]  = '{1, 2, 3, 4, 5, 0, 1};

   initial begin
      rst = 1'b1;
      cnt_set = 0; cnt_en = 0; cnt_val = '0;
      flag_set = 0; flag_clear = 0; byp_en = 0; byp_data = '0;
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // Free-running enable wraps at 7 (A) and at 5 after starting from 2 (B).
      apply_stimulus(0, 1, 3'd0, 0, 0, 0, 6'h00);
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         check_output("wrap cnt_a", 32'(cnt_a), 32'(exp_wrap_a[i]));
         check_output("wrap cnt_b", 32'(cnt_b), 32'(exp_wrap_b[i]));
      end

      // Set beats enable; B loads an out-of-range 6 and wraps from it.
      apply_stimulus(1, 0, 3'd3, 0, 0, 0, 6'h00);
      next_cycle();
      check_output("load3 cnt_a", 32'(cnt_a), 32'd3);
      apply_stimulus(1, 1, 3'd6, 0, 0, 0, 6'h00);
      next_cycle();
      check_output("setprio cnt_a", 32'(cnt_a), 32'd6);
      check_output("setprio cnt_b", 32'(cnt_b), 32'd6);
      apply_stimulus(0, 1, 3'd0, 0, 0, 0, 6'h00);
      next_cycle();
      check_output("after6 cnt_a", 32'(cnt_a), 32'd7);
      check_output("oor wrap cnt_b", 32'(cnt_b), 32'd0);
      next_cycle();
      check_output("wrap7 cnt_a", 32'(cnt_a), 32'd0);
      check_output("oor next cnt_b", 32'(cnt_b), 32'd1);

      // Non-power-of-two wrap from zero.
      apply_stimulus(1, 0, 3'd0, 0, 0, 0, 6'h00);
      next_cycle();
      apply_stimulus(0, 1, 3'd0, 0, 0, 0, 6'h00);
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         check_output("np2 cnt_b", 32'(cnt_b), 32'(exp_np2_b[i]));
         check_output("np2 cnt_a", 32'(cnt_a), 32'(i + 1));
      end

      // Flag set, both (clear-wins vs set-wins), hold, clear.
      apply_stimulus(0, 0, 3'd0, 1, 0, 0, 6'h00);
      next_cycle();
      check_output("set flag_a", 32'(flag_a), 32'd1);
      check_output("set flag_b", 32'(flag_b), 32'd1);
      apply_stimulus(0, 0, 3'd0, 1, 1, 0, 6'h00);
      next_cycle();
      check_output("both flag_a", 32'(flag_a), 32'd0);
      check_output("both flag_b", 32'(flag_b), 32'd1);
      apply_stimulus(0, 0, 3'd0, 0, 0, 0, 6'h00);
      next_cycle();
      check_output("hold flag_a", 32'(flag_a), 32'd0);
      check_output("hold flag_b", 32'(flag_b), 32'd1);
      apply_stimulus(0, 0, 3'd0, 0, 1, 0, 6'h00);
      next_cycle();
      check_output("clear flag_b", 32'(flag_b), 32'd0);

      // Bypass: same-cycle pass-through, hold on disable, pass-through again.
      apply_stimulus(0, 0, 3'd0, 0, 0, 1, 6'h2A);
      #1;
      check_output("byp pass a", 32'(byp_a), 32'h2A);
      check_output("byp pass b", 32'(byp_b), 32'hA);
      next_cycle();
      apply_stimulus(0, 0, 3'd0, 0, 0, 0, 6'h15);
      #1;
      check_output("byp hold a", 32'(byp_a), 32'h2A);
      check_output("byp hold b", 32'(byp_b), 32'hA);
      next_cycle();
      check_output("byp hold2 a", 32'(byp_a), 32'h2A);
      apply_stimulus(0, 0, 3'd0, 0, 0, 1, 6'h15);
      #1;
      check_output("byp reen a", 32'(byp_a), 32'h15);
      check_output("byp reen b", 32'(byp_b), 32'h5);
      next_cycle();

      // Asynchronous reset mid-cycle clears everything at once.
      apply_stimulus(1, 0, 3'd5, 1, 0, 0, 6'h00);
      next_cycle();
      #3 rst = 1'b1;
      #1;
      check_output("rst cnt_a", 32'(cnt_a), 32'd0);
      check_output("rst cnt_b", 32'(cnt_b), 32'd2);
      check_output("rst flag_a", 32'(flag_a), 32'd0);
      check_output("rst byp_a", 32'(byp_a), 32'h00);
      check_output("rst byp_b", 32'(byp_b), 32'h0);
      byp_en   = 1'b1;
      byp_data = 6'h33;
      #1;
      check_output("rst pass a", 32'(byp_a), 32'h33);
      next_cycle();
      check_output("rst held cnt_a", 32'(cnt_a), 32'd0);
      #1;
      rst    = 1'b0;
      byp_en = 1'b0;

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         rst        = ($urandom_range(0, 59) == 0);
         cnt_set    = ($urandom_range(0, 3) == 0);
         cnt_en     = $urandom_range(0, 1);
         cnt_val    = 3'($urandom_range(0, 7));
         flag_set   = $urandom_range(0, 1);
         flag_clear = $urandom_range(0, 1);
         byp_en     = $urandom_range(0, 1);
         byp_data   = 6'($urandom_range(0, 63));
      end
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_stream_beat_state.md
Name: bp_stream_beat_state

Overview:
- Per-transaction state store for a BedRock stream pump.
- Bundles three independent sequential elements:
  - a settable, enabled beat counter (bsg_counter_set_en function);
  - a set/clear "streaming" flag (bsg_dff_reset_set_clear function);
  - an enable-bypass capture register for the critical address (bsg_dff_en_bypass function).
- Sits between the pump's combinational header/handshake logic and the clock. It holds only the cycle-to-cycle state of a multi-beat transfer.

Parameters:
- max_val_p, 7: maximum counter value. Counter width cw = clog2(max_val_p+1), minimum 1.
- reset_val_p, 0: counter value after reset. Must be <= max_val_p.
- clear_over_set_p, 1: 1 means clear wins when set and clear are both asserted; 0 means set wins.
- byp_width_p, 6: width of the bypass register data.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-high.
- cnt_set_i  in  1  load cnt_val_i into the counter.
- cnt_en_i  in  1  increment the counter.
- cnt_val_i  in  cw  load value.
- cnt_o  out  cw  registered counter value.
- flag_set_i  in  1  set the streaming flag.
- flag_clear_i  in  1  clear the streaming flag.
- flag_o  out  1  registered flag.
- byp_en_i  in  1  capture/bypass enable.
- byp_data_i  in  byp_width_p  data to capture.
- byp_data_o  out  byp_width_p  byp_en_i ? byp_data_i : stored value.

Behaviour:
- Reset (asynchronous, immediate on reset_i rising, held while high):
  - counter = reset_val_p;
  - flag = 0;
  - bypass storage = 0. byp_data_o still follows byp_data_i whenever byp_en_i=1, even during reset.
- Counter, updated each rising edge with reset_i low; priority set > enable:
  - cnt_set_i=1: count <= cnt_val_i, regardless of cnt_en_i.
  - else cnt_en_i=1: count <= (count==max_val_p) ? 0 : count+1. The wrap is explicit, so it is also correct when max_val_p+1 is not a power of two.
  - else hold.
- Counter output timing: cnt_o is the register value with no combinational path from inputs. Latency is 1 cycle from set/enable to the new cnt_o.
- Flag, each edge:
  - set only: flag <= 1.
  - clear only: flag <= 0.
  - both: flag <= ~clear_over_set_p. With the default of 1 the result is 0.
  - neither: hold.
  - flag_o is registered.
- Bypass register:
  - byp_en_i=1: byp_data_o = byp_data_i combinationally (zero latency), and storage <= byp_data_i at the edge.
  - byp_en_i=0: byp_data_o = storage; storage holds.
- The three elements share only clk_i/reset_i; no cross-coupling inside the block.
- Reset mid-transfer: all state returns to reset values at once; the next transfer starts from reset_val_p with flag 0.
- Out-of-range load: cnt_val_i > max_val_p is illegal. If it occurs, the counter loads it unmodified, and the next increment from a value >= max_val_p wraps to 0.

Optional Feature:
- Macro: BP_STREAM_BEAT_STATE_ASSERT_EN.
- When defined, simulation-only checks are compiled in. An error is reported on any rising edge with reset_i low where:
  - cnt_set_i=1 and cnt_val_i > max_val_p;
  - flag_set_i and flag_clear_i are both asserted and clear_over_set_p is not 0 or 1.
- Elaboration also checks reset_val_p <= max_val_p.
- When undefined, no checks exist and the synthesized logic is identical.

Decomposition:
- Shared package bp_stream_state_pkg holds:
  - a clog2-safe width function for cw;
  - the constant default_stream_words = 8, from which max_val_p = default_stream_words-1.
- One natural sub-module: bp_stream_beat_counter, implementing the set/enable/wrap counter. The flag and bypass register are written inline in the top module.

Test Plan:
- Reset then wrap: assert reset_i asynchronously mid-cycle -> cnt_o=0, flag_o=0, stored bypass=0 immediately. Release, hold cnt_en_i=1 for 9 cycles -> cnt_o runs 1..7, 0, 1.
- Set priority: count=3, cnt_set_i=1 and cnt_en_i=1 with cnt_val_i=6 -> cnt_o=6 next cycle, not 4. Next cycle en only -> 7, then 0.
- Non-power-of-two wrap: max_val_p=5, enable 7 cycles from 0 -> 1, 2, 3, 4, 5, 0, 1.
- Flag: set -> flag_o=1 next cycle. Set and clear together with clear_over_set_p=1 -> 0; rerun with clear_over_set_p=0 -> 1. Neither asserted -> holds.
- Bypass: byp_en_i=1, byp_data_i=0x2A -> byp_data_o=0x2A the same cycle. Drop byp_en_i and change byp_data_i to 0x15 -> byp_data_o stays 0x2A. Re-enable -> 0x15 immediately.
- Assertion build: with BP_STREAM_BEAT_STATE_ASSERT_EN defined, load cnt_val_i=7 with max_val_p=5 -> error reported. Without the macro -> no message.
